// File: rtl/fft_sequencer.sv
// fft_sequencer
// Top-level sequencer for the radix-2 FFT datapath. Runs one transform per start:
// loads the sample banks, steps stage control through stages 0..NUMSTAGES-1 with a
// one-cycle enable gap between stages, then unloads the result. A per-stage watchdog
// moves the block to a sticky error state if a stage never completes.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              begin a transform (honoured only in IDLE or ERR)
//   in_valid/in_ready  load handshake; load_addr is the bank write address
//   ld_data, en        to stage control: data-init phase, stage enable
//   stage_num          to stage control: current stage index
//   stage_done         from stage control: level, stage finished
//   out_valid/out_ready unload handshake; out_addr is the bank read address
//   busy, done, err    status: active, end-of-transform pulse, sticky timeout
// All outputs are registered and reset to 0.
module fft_sequencer #(
    parameter int unsigned NUMSTAGES     = 5,
    parameter int unsigned STAGE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ld_data,
    output logic                 en,
    output logic [2:0]           stage_num,
    input  logic                 stage_done,
    output logic [NUMSTAGES-3:0] load_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUMSTAGES-3:0] out_addr,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned AW = NUMSTAGES - 2;
    localparam logic [AW-1:0] LastAddr  = {AW{1'b1}};
    localparam logic [2:0]    LastStage = 3'(NUMSTAGES - 1);
    localparam logic [7:0]    WdLast    = 8'(STAGE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StGap,
        StUnload,
        StDone,
        StErr
    } state_e;

    state_e          r_state, w_state_d;
    logic [AW-1:0]   r_load_addr, w_load_addr_d;
    logic [AW-1:0]   r_out_addr, w_out_addr_d;
    logic [2:0]      r_stage, w_stage_d;
    logic [7:0]      r_wd, w_wd_d;
    // Set once stage_done has been seen low in the current stage, so a stale
    // stage_done left over from the previous stage cannot end this one.
    logic            r_armed, w_armed_d;
    logic            r_err, w_err_d;
    logic            r_in_ready, r_ld_data, r_en, r_out_valid, r_busy, r_done;
    logic            w_in_ready_d, w_ld_data_d, w_en_d, w_out_valid_d, w_busy_d, w_done_d;

    always_comb begin
        w_state_d     = r_state;
        w_load_addr_d = r_load_addr;
        w_out_addr_d  = r_out_addr;
        w_stage_d     = r_stage;
        w_wd_d        = r_wd;
        w_armed_d     = r_armed;
        w_err_d       = r_err;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d     = StLoad;
                    w_load_addr_d = '0;
                end
            end
            StLoad: begin
                if (in_valid) begin
                    w_load_addr_d = r_load_addr + 1'b1;
                    if (r_load_addr == LastAddr) begin
                        w_state_d = StRun;
                        w_stage_d = '0;
                        w_wd_d    = '0;
                        w_armed_d = 1'b0;
                    end
                end
            end
            StRun: begin
                // Completion wins over the watchdog in the same cycle.
                if (stage_done && r_armed) begin
                    w_state_d = StGap;
                end else if (r_wd == WdLast) begin
                    w_state_d = StErr;
                    w_err_d   = 1'b1;
                end else begin
                    w_wd_d = r_wd + 8'd1;
                    if (!stage_done) begin
                        w_armed_d = 1'b1;
                    end
                end
            end
            StGap: begin
                if (r_stage == LastStage) begin
                    w_state_d    = StUnload;
                    w_out_addr_d = '0;
                end else begin
                    w_state_d = StRun;
                    w_stage_d = r_stage + 3'd1;
                    w_wd_d    = '0;
                    w_armed_d = 1'b0;
                end
            end
            StUnload: begin
                if (out_ready) begin
                    w_out_addr_d = r_out_addr + 1'b1;
                    if (r_out_addr == LastAddr) begin
                        w_state_d = StDone;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
                w_stage_d = '0;
            end
            StErr: begin
                if (start) begin
                    w_state_d     = StLoad;
                    w_load_addr_d = '0;
                    w_err_d       = 1'b0;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        w_in_ready_d  = (w_state_d == StLoad);
        w_ld_data_d   = (w_state_d == StLoad);
        w_en_d        = (w_state_d == StRun);
        w_out_valid_d = (w_state_d == StUnload);
        w_busy_d      = (w_state_d != StIdle) && (w_state_d != StErr);
        w_done_d      = (w_state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_load_addr <= '0;
            r_out_addr  <= '0;
            r_stage     <= '0;
            r_wd        <= '0;
            r_armed     <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_ld_data   <= 1'b0;
            r_en        <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_load_addr <= w_load_addr_d;
            r_out_addr  <= w_out_addr_d;
            r_stage     <= w_stage_d;
            r_wd        <= w_wd_d;
            r_armed     <= w_armed_d;
            r_err       <= w_err_d;
            r_in_ready  <= w_in_ready_d;
            r_ld_data   <= w_ld_data_d;
            r_en        <= w_en_d;
            r_out_valid <= w_out_valid_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
        end
    end

    assign in_ready  = r_in_ready;
    assign ld_data   = r_ld_data;
    assign en        = r_en;
    assign stage_num = r_stage;
    assign load_addr = r_load_addr;
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer (NUMSTAGES=5, STAGE_TIMEOUT=64).
// A behavioural model driven by the same inputs predicts every output each cycle;
// scenario checks pin latencies, stage order, gap widths and error timing.
module tb_fft_sequencer;

    localparam int NS = 5;
    localparam int TO = 64;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, in_ready, ld_data, en, stage_done;
    logic [2:0] stage_num, load_addr, out_addr;
    logic       out_valid, out_ready, busy, done, err;

    always #5 clk = ~clk;

    fft_sequencer #(.NUMSTAGES(NS), .STAGE_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ld_data   (ld_data),
        .en        (en),
        .stage_num (stage_num),
        .stage_done(stage_done),
        .load_addr (load_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int PhIdle = 0, PhLoad = 1, PhRun = 2, PhGap = 3, PhUnload = 4,
                   PhDone = 5, PhErr = 6;
    int m_ph, m_beats, m_obeats, m_stage, m_age;
    bit m_low, m_err;

    task automatic model_reset();
        m_ph = PhIdle; m_beats = 0; m_obeats = 0; m_stage = 0; m_age = 0;
        m_low = 0; m_err = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs present at that edge.
    task automatic model_step();
        case (m_ph)
            PhIdle: if (start) begin m_ph = PhLoad; m_beats = 0; end
            PhLoad: if (in_valid) begin
                m_beats++;
                if (m_beats == BD) begin
                    m_ph = PhRun; m_beats = 0; m_stage = 0; m_age = 0; m_low = 0;
                end
            end
            PhRun: begin
                m_age++;  // RUN cycles elapsed in this stage
                if (stage_done && m_low) m_ph = PhGap;
                else if (m_age == TO) begin m_ph = PhErr; m_err = 1; end
                else if (!stage_done) m_low = 1;
            end
            PhGap: begin
                if (m_stage == NS - 1) begin m_ph = PhUnload; m_obeats = 0; end
                else begin m_ph = PhRun; m_stage++; m_age = 0; m_low = 0; end
            end
            PhUnload: if (out_ready) begin
                m_obeats++;
                if (m_obeats == BD) m_ph = PhDone;
            end
            PhDone: begin m_ph = PhIdle; m_stage = 0; end
            PhErr: if (start) begin m_ph = PhLoad; m_beats = 0; m_err = 0; end
            default: m_ph = PhIdle;
        endcase
    endtask

    // ---------------- monitor statistics ----------------
    int en_runs[$], gaps[$], rise_stage[$], rise_cyc[$], ld_addrs[$], out_addrs[$];
    int run_cnt, gap_cnt, done_cnt, ld_cnt, ov_cnt, err_rise_cyc;
    bit have_fall, p_en, p_err;

    task automatic clear_stats();
        en_runs.delete(); gaps.delete(); rise_stage.delete(); rise_cyc.delete();
        ld_addrs.delete(); out_addrs.delete();
        run_cnt = 0; gap_cnt = 0; done_cnt = 0; ld_cnt = 0; ov_cnt = 0;
        err_rise_cyc = -1; have_fall = 0;
    endtask

    // Compare process: model vs DUT every cycle, plus statistics.
    initial begin
        model_reset();
        clear_stats();
        p_en = 0; p_err = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin cyc++; model_step(); end
            #1;
            chk("in_ready",  int'(in_ready),  int'(m_ph == PhLoad));
            chk("ld_data",   int'(ld_data),   int'(m_ph == PhLoad));
            chk("en",        int'(en),        int'(m_ph == PhRun));
            chk("out_valid", int'(out_valid), int'(m_ph == PhUnload));
            chk("busy",      int'(busy),      int'(m_ph != PhIdle && m_ph != PhErr));
            chk("done",      int'(done),      int'(m_ph == PhDone));
            chk("err",       int'(err),       int'(m_err));
            chk("stage_num", int'(stage_num), m_stage);
            chk("load_addr", int'(load_addr), m_beats % BD);
            chk("out_addr",  int'(out_addr),  m_obeats % BD);
            if (en && !p_en) begin
                rise_stage.push_back(int'(stage_num));
                rise_cyc.push_back(cyc);
                if (have_fall) gaps.push_back(gap_cnt);
                run_cnt = 0;
            end
            if (en) run_cnt++;
            if (!en && p_en) begin en_runs.push_back(run_cnt); have_fall = 1; gap_cnt = 0; end
            if (!en) gap_cnt++;
            if (done) done_cnt++;
            if (ld_data) ld_cnt++;
            if (out_valid) ov_cnt++;
            if (err && !p_err) err_rise_cyc = cyc;
            p_en = en; p_err = err;
        end
    end

    // ---------------- input driver / stage-control stand-in ----------------
    int s_cycles = 31;      // stage_done rises this many cycles after en rises
    int kill_stage = -1;    // stage whose stage_done never arrives
    bit stale_mode = 0;     // hold stage_done high through GAP and 3 RUN cycles
    int iv_mode = 0, or_mode = 0;
    int sc_cnt = 0, force_cnt = 0, ld_cyc = 0, stall_left = 0;
    bit stall_used = 0, p_en_d = 0, sd;

    initial begin
        stage_done = 0; in_valid = 0; out_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !en) sc_cnt = 0; else sc_cnt++;
            if (stale_mode && p_en_d && !en && busy) force_cnt = 4;
            else if (force_cnt > 0) force_cnt--;
            if (!rst_n) force_cnt = 0;
            p_en_d = en;
            sd = (sc_cnt >= s_cycles);
            if (en && int'(stage_num) == kill_stage) sd = 0;
            stage_done = sd || (force_cnt > 0);

            case (iv_mode)
                1: begin
                    if (ld_data) begin in_valid = ld_cyc[0]; ld_cyc++; end
                    else begin in_valid = 0; ld_cyc = 0; end
                end
                2: in_valid = ($urandom_range(0, 3) != 0);
                default: in_valid = 1;
            endcase
            case (or_mode)
                1: begin
                    if (!busy) stall_used = 0;
                    if (out_valid && out_addr == 3'd3 && !stall_used && stall_left == 0) begin
                        stall_left = 5; stall_used = 1;
                    end
                    if (stall_left > 0) begin
                        out_ready = 0; stall_left--;
                        chk("stall_addr_hold", int'(out_addr), 3);
                    end else out_ready = 1;
                end
                2: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1;
            endcase
            if (in_valid && in_ready) ld_addrs.push_back(int'(load_addr));
            if (out_ready && out_valid) out_addrs.push_back(int'(out_addr));
        end
    end

    // ---------------- scenario helpers ----------------
    task automatic pulse_start(output int st);
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        st = cyc;  // edge that sampled start
    endtask

    task automatic wait_idle(input int budget, input int poke_at, output int end_cyc);
        int n = 0;
        while (busy && n < budget) begin
            start = (n == poke_at);
            @(negedge clk);
            n++;
        end
        start = 0;
        chk("wait_budget", int'(busy), 0);
        end_cyc = cyc;
    endtask

    task automatic check_sweeps(input string tag);
        chk({tag, "_ld_beats"}, ld_addrs.size(), BD);
        for (int i = 0; i < ld_addrs.size(); i++) chk({tag, "_ld_addr"}, ld_addrs[i], i);
        chk({tag, "_out_beats"}, out_addrs.size(), BD);
        for (int i = 0; i < out_addrs.size(); i++) chk({tag, "_out_addr"}, out_addrs[i], i);
    endtask

    task automatic check_stages(input string tag, input int run_len);
        chk({tag, "_en_rises"}, rise_stage.size(), NS);
        for (int i = 0; i < rise_stage.size(); i++) chk({tag, "_stage_seq"}, rise_stage[i], i);
        chk({tag, "_gap_count"}, gaps.size(), NS - 1);
        for (int i = 0; i < gaps.size(); i++) chk({tag, "_gap_len"}, gaps[i], 1);
        for (int i = 0; i < en_runs.size(); i++) chk({tag, "_run_len"}, en_runs[i], run_len);
        chk({tag, "_done_cycles"}, done_cnt, 1);
    endtask

    int st, fin;

    initial begin
        rst_n = 0; start = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_outs", int'({in_ready, ld_data, en, out_valid, done, stage_num,
                                load_addr, out_addr}), 0);

        // Nominal: 8 + 5*(31+1) + 8 + 1 = 177 edges from start edge to busy low.
        clear_stats();
        pulse_start(st);
        wait_idle(2000, -1, fin);
        chk("nom_latency", fin - st, 177);
        check_stages("nom", 31);
        check_sweeps("nom");
        chk("nom_ld_cycles", ld_cnt, 8);
        chk("nom_ov_cycles", ov_cnt, 8);

        // Backpressure: load takes 16 cycles, unload stalls 5 cycles at addr 3.
        iv_mode = 1; or_mode = 1;
        clear_stats();
        pulse_start(st);
        wait_idle(2000, -1, fin);
        chk("bp_latency", fin - st, 177 + 8 + 5);
        chk("bp_ld_cycles", ld_cnt, 16);
        chk("bp_ov_cycles", ov_cnt, 13);
        chk("bp_err", int'(err), 0);
        check_sweeps("bp");
        iv_mode = 0; or_mode = 0;

        // Timeout in stage 2, then restart from ERR.
        kill_stage = 2;
        clear_stats();
        pulse_start(st);
        wait_idle(2000, -1, fin);
        chk("to_err", int'(err), 1);
        chk("to_en", int'(en), 0);
        chk("to_rises", rise_cyc.size(), 3);
        if (rise_cyc.size() >= 3) chk("to_delay", err_rise_cyc - rise_cyc[2], 64);
        kill_stage = -1;
        clear_stats();
        pulse_start(st);
        chk("restart_err", int'(err), 0);
        chk("restart_ld", int'(ld_data), 1);
        chk("restart_addr", int'(load_addr), 0);
        wait_idle(2000, -1, fin);
        check_stages("restart", 31);

        // Completion on the watchdog's last cycle, plus start poked during RUN.
        s_cycles = 64;
        clear_stats();
        pulse_start(st);
        wait_idle(3000, 40, fin);
        chk("edge_latency", fin - st, 8 + 5 * 65 + 8 + 1);
        chk("edge_err", int'(err), 0);
        check_stages("edge", 64);
        s_cycles = 31;

        // Stale stage_done held through GAP and into the next stage.
        stale_mode = 1;
        clear_stats();
        pulse_start(st);
        wait_idle(2000, -1, fin);
        chk("stale_latency", fin - st, 177);
        check_stages("stale", 31);
        stale_mode = 0;

        // Asynchronous reset in the middle of stage 3.
        clear_stats();
        pulse_start(st);
        begin
            int n = 0;
            while (!(en && stage_num == 3'd3) && n < 500) begin @(negedge clk); n++; end
            chk("reach_stage3", int'(stage_num), 3);
        end
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_outs", int'({in_ready, ld_data, en, out_valid, busy, done, err,
                               stage_num, load_addr, out_addr}), 0);
        @(negedge clk); rst_n = 1;
        clear_stats();
        pulse_start(st);
        wait_idle(2000, -1, fin);
        chk("arst_latency", fin - st, 177);
        check_stages("arst", 31);

        // Randomized handshakes and stage lengths.
        iv_mode = 2; or_mode = 2;
        for (int t = 0; t < 4; t++) begin
            s_cycles = $urandom_range(2, 40);
            clear_stats();
            pulse_start(st);
            wait_idle(4000, $urandom_range(20, 100), fin);
            chk("rnd_err", int'(err), 0);
            check_stages("rnd", s_cycles);
            check_sweeps("rnd");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Top-level sequencer for the radix-2 FFT datapath. It sits directly upstream of `fft_stage_control` and drives that block's `ld_data`, `en` and `stage_num` inputs, and consumes its `stage_done`. It runs one transform per `start`: it loads the sample banks, steps through stages 0..NUMSTAGES-1 with a one-cycle disable gap between stages, then unloads the result. A watchdog flags a stage that never completes.

## Interface
- NUMSTAGES, 5, number of butterfly stages (log2 N); legal range 3..8; bank depth BD = 2^(NUMSTAGES-2)
- STAGE_TIMEOUT, 64, max cycles spent in one stage before error; legal range 2..255

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a transform; sampled only in IDLE or ERR
- in_valid  in  1  load beat offered (4 samples, one per bank)
- in_ready  out  1  load beat accepted when in_valid & in_ready
- ld_data  out  1  to stage control: data-initialisation phase
- en  out  1  to stage control: stage enable
- stage_num  out  3  to stage control: current stage index
- stage_done  in  1  from stage control: level, high once the stage counter reaches its end
- load_addr  out  NUMSTAGES-2  bank write address during LOAD
- out_valid  out  1  unload beat presented
- out_ready  in  1  unload beat consumed when out_valid & out_ready
- out_addr  out  NUMSTAGES-2  bank read address during UNLOAD
- busy  out  1  high in every state except IDLE and ERR
- done  out  1  one-cycle pulse at end of transform
- err  out  1  sticky stage-timeout flag

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, and all counters reset to 0.
- IDLE: if start=1, go to LOAD and clear load_addr.
- LOAD: ld_data=1, in_ready=1, en=0.
  - Each accepted beat increments load_addr.
  - The beat accepted at load_addr=BD-1 moves the block to RUN with stage_num=0 and the watchdog cleared. load_addr wraps to 0.
  - in_valid=0 stalls the block with no timeout.
- RUN: en=1, ld_data=0, stage_num held. The watchdog increments every cycle.
  - stage_done=1: go to GAP. stage_done takes priority over the watchdog in the same cycle.
  - stage_done=0 and watchdog = STAGE_TIMEOUT-1: go to ERR.
- GAP: exactly one cycle with en=0. This lets stage control clear its counter and its stage_done.
  - If stage_num = NUMSTAGES-1, go to UNLOAD with out_addr=0.
  - Otherwise increment stage_num, clear the watchdog, and go to RUN.
  - stage_done is ignored in GAP.
- UNLOAD: out_valid=1.
  - Each consumed beat increments out_addr.
  - The beat consumed at out_addr=BD-1 moves the block to DONE.
  - out_ready=0 stalls the block indefinitely.
- DONE: done=1 for one cycle, then go to IDLE. stage_num returns to 0.
- ERR: err=1, busy=0, en=0, ld_data=0.
  - start=1 clears err and goes to LOAD.
  - Only rst_n or start leaves ERR.
- start is ignored outside IDLE and ERR.
- stage_done outside RUN is ignored.
- rst_n low at any time, including mid-stage: the block returns to IDLE with all outputs 0 immediately (asynchronous). Because en=0, stage control also clears.

## Timing
- start high at edge k: LOAD is entered at k+1, so in_ready and ld_data are high from k+1.
- Last load beat accepted at edge m: en=1 and stage_num=0 from m+1.
- stage_done first seen high at edge r: en=0 from r+1 (GAP). en=1 with the next stage_num from r+2.
- Minimum stage-to-stage overhead is 2 cycles (detect plus GAP).
- Last unload beat consumed at edge u: done=1 during u+1 to u+2, and busy=0 from u+2.
- Minimum total latency with ideal handshakes and a stage-control run of S cycles per stage: 1 + BD + NUMSTAGES·(S+1) + BD + 1 cycles.

## Test plan
- Nominal (NUMSTAGES=5, BD=8): stage_done model asserts 31 cycles after each en rise; in_valid and out_ready held at 1.
  - Required: stage_num steps 0,1,2,3,4.
  - Required: en drops for exactly 1 cycle between stages.
  - Required: load_addr and out_addr each sweep 0..7 once.
  - Required: done pulses once, for 1 cycle.
- Backpressure: in_valid toggles every other cycle, and out_ready is low for 5 cycles at out_addr=3.
  - Required: 8 load beats take 16 cycles.
  - Required: out_addr holds at 3 during the stall.
  - Required: no err.
- Timeout (STAGE_TIMEOUT=64): stage_done is never asserted in stage 2.
  - Required: ERR is entered exactly 64 cycles after en rose for stage 2.
  - Required: err=1 and en=0.
  - Required: a subsequent start clears err and restarts LOAD at load_addr=0.
- Simultaneous events:
  - stage_done rises on the same cycle the watchdog hits 63: GAP is taken and err stays 0.
  - start asserted in RUN: ignored.
- Asynchronous reset mid-stage 3 (between clock edges): all outputs go to 0 immediately and the state becomes IDLE. A following start runs a clean transform beginning at stage 0.
- Stale stage_done: stage_done is held high through GAP. Required: the block still spends exactly 1 cycle in GAP, and the next stage does not complete before stage_done has been seen low.
